pong_game_ctl: RTL and testbench

Top-level game sequencer for Classic Pong. Owns the match state machine (idle, serve, rally, point, game over), enables and recentres the ball, gates paddle movement, and keeps both players' scores. Sits between the board inputs and the per-object control blocks (ball, left/right paddle) and feeds score/state to the display path.

---
 rtl/pong_pkg.sv | 30 +++
 rtl/pong_game_ctl_if.sv | 33 +++
 rtl/pong_serve_timer.sv | 27 ++
 rtl/pong_game_ctl.sv | 115 +++++++++++
 tb/tb_pong_game_ctl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// Shared Pong definitions: match state encoding, winner encoding, board
// dimension defaults used by the game controller and the ball/paddle blocks,
// and a saturating score increment.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_RUNNING   = 3'd2,
        ST_POINT     = 3'd3,
        ST_GAME_OVER = 3'd4
    } game_state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10
    } winner_t;

    localparam int unsigned BOARD_WIDTH  = 40;
    localparam int unsigned BOARD_HEIGHT = 30;
    localparam int unsigned BALL_X_W     = 6;
    localparam int unsigned SCORE_W      = 4;

    // Scores stick at 15 rather than wrapping to 0.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s == '1) ? s : s + 1'b1;
    endfunction

endpackage

// File: rtl/pong_game_ctl_if.sv
// Board-side bundle of the Pong game controller.
//   start_i      button level (debounced)
//   ball_x_i     current ball column
//   ball_en_o    ball may move
//   ball_reset_o one-cycle recentre pulse
//   paddle_en_o  paddles may move
//   p1/p2_score  player scores
//   winner_o     00 none, 01 P1, 10 P2
//   state_o      match state for display
// master: the board / display side; slave: pong_game_ctl.
interface pong_game_ctl_if;
    logic       start_i;
    logic [5:0] ball_x_i;
    logic       ball_en_o;
    logic       ball_reset_o;
    logic       paddle_en_o;
    logic [3:0] p1_score_o;
    logic [3:0] p2_score_o;
    logic [1:0] winner_o;
    logic [2:0] state_o;

    modport master (
        output start_i, ball_x_i,
        input  ball_en_o, ball_reset_o, paddle_en_o,
        input  p1_score_o, p2_score_o, winner_o, state_o
    );

    modport slave (
        input  start_i, ball_x_i,
        output ball_en_o, ball_reset_o, paddle_en_o,
        output p1_score_o, p2_score_o, winner_o, state_o
    );
endinterface

// File: rtl/pong_serve_timer.sv
// Serve hold-off timer. Counts enabled cycles from 0; done is high during the
// enabled cycle in which the count reaches SERVE_DELAY-1.
//   clk_i, rst_n_i  clock, synchronous active-low reset
//   clear           restart the count at 0
//   enable          count this cycle
//   done            terminal-count indication (combinational)
module pong_serve_timer #(
    parameter int unsigned SERVE_DELAY = 25000000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear,
    input  logic enable,
    output logic done
);
    localparam logic [31:0] LAST = 32'(SERVE_DELAY - 1);

    logic [31:0] count;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i)    count <= '0;
        else if (clear)  count <= '0;
        else if (enable) count <= count + 32'd1;
    end

    assign done = enable && (count == LAST);
endmodule

// File: rtl/pong_game_ctl.sv
// Pong match sequencer: idle / serve / rally / point / game-over FSM, ball
// and paddle enables, ball recentre pulse, scores and winner.
//   clk_i    system clock
//   rst_n_i  synchronous active-low reset
//   game     pong_game_ctl_if.slave bundle (all outputs registered)
module pong_game_ctl
    import pong_pkg::*;
#(
    parameter int unsigned GAME_WIDTH  = BOARD_WIDTH,
    parameter int unsigned SCORE_LIMIT = 9,
    parameter int unsigned SERVE_DELAY = 25000000
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    pong_game_ctl_if.slave game
);
    localparam logic [5:0] RIGHT_COL = 6'(GAME_WIDTH - 1);
    localparam logic [3:0] LIMIT     = 4'(SCORE_LIMIT);

    game_state_t state, state_next;
    logic        start_q, start_edge_q;
    logic [3:0]  p1_score, p2_score, p1_next, p2_next;
    winner_t     winner, winner_next;
    logic        p1_last, p1_last_next;
    logic        ball_en, ball_reset, paddle_en;
    logic        serve_done;

    pong_serve_timer #(.SERVE_DELAY(SERVE_DELAY)) u_serve_timer (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clear   (state != ST_SERVE),
        .enable  (state == ST_SERVE),
        .done    (serve_done)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            // Held as if already pressed, so a button kept down through
            // reset needs a fresh press to start a match.
            start_q      <= 1'b1;
            start_edge_q <= 1'b0;
            state        <= ST_IDLE;
            p1_score     <= '0;
            p2_score     <= '0;
            winner       <= WIN_NONE;
            p1_last      <= 1'b0;
            ball_en      <= 1'b0;
            ball_reset   <= 1'b0;
            paddle_en    <= 1'b0;
        end else begin
            start_q      <= game.start_i;
            start_edge_q <= game.start_i & ~start_q;
            state        <= state_next;
            p1_score     <= p1_next;
            p2_score     <= p2_next;
            winner       <= winner_next;
            p1_last      <= p1_last_next;
            // Outputs are registered from the next state so they line up
            // with state_o.
            ball_en      <= (state_next == ST_RUNNING);
            paddle_en    <= (state_next == ST_SERVE) || (state_next == ST_RUNNING);
            ball_reset   <= (state_next == ST_SERVE) && (state != ST_SERVE);
        end
    end

    always_comb begin
        state_next   = state;
        p1_next      = p1_score;
        p2_next      = p2_score;
        winner_next  = winner;
        p1_last_next = p1_last;
        unique case (state)
            ST_IDLE, ST_GAME_OVER: begin
                if (start_edge_q) begin
                    state_next  = ST_SERVE;
                    p1_next     = '0;
                    p2_next     = '0;
                    winner_next = WIN_NONE;
                end
            end
            ST_SERVE: begin
                if (serve_done) state_next = ST_RUNNING;
            end
            ST_RUNNING: begin
                // Right wall checked first: P1 wins a tie on a 1-wide board.
                if (game.ball_x_i == RIGHT_COL) begin
                    p1_next      = sat_inc(p1_score);
                    p1_last_next = 1'b1;
                    state_next   = ST_POINT;
                end else if (game.ball_x_i == '0) begin
                    p2_next      = sat_inc(p2_score);
                    p1_last_next = 1'b0;
                    state_next   = ST_POINT;
                end
            end
            ST_POINT: begin
                if ((p1_last ? p1_score : p2_score) == LIMIT) begin
                    state_next  = ST_GAME_OVER;
                    winner_next = p1_last ? WIN_P1 : WIN_P2;
                end else begin
                    state_next  = ST_SERVE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign game.state_o      = state;
    assign game.ball_en_o    = ball_en;
    assign game.ball_reset_o = ball_reset;
    assign game.paddle_en_o  = paddle_en;
    assign game.p1_score_o   = p1_score;
    assign game.p2_score_o   = p2_score;
    assign game.winner_o     = winner;
endmodule

// File: tb/tb_pong_game_ctl.sv
// Scenario bench for pong_game_ctl with SERVE_DELAY=4, SCORE_LIMIT=3,
// GAME_WIDTH=40. Each step holds the inputs for one clock and the outputs
// expected right after that edge.
module tb_pong_game_ctl;
    import pong_pkg::*;

    typedef struct packed {
        logic [2:0] st;
        logic       ben;
        logic       brst;
        logic       pen;
        logic [3:0] p1;
        logic [3:0] p2;
        logic [1:0] win;
    } obs_t;

    typedef struct packed {
        logic       rst_n;
        logic       start;
        logic [5:0] bx;
        obs_t       exp;
    } step_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   compared = 0;
    int   mismatched = 0;
    step_t sb[$];

    pong_game_ctl_if bus();

    pong_game_ctl #(
        .GAME_WIDTH (40),
        .SCORE_LIMIT(3),
        .SERVE_DELAY(4)
    ) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .game   (bus)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(input game_state_t s, input logic ben, input logic brst,
                                input logic pen, input logic [3:0] a, input logic [3:0] b,
                                input winner_t w);
        obs_t o;
        o.st = s; o.ben = ben; o.brst = brst; o.pen = pen;
        o.p1 = a; o.p2 = b; o.win = w;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.st = bus.state_o; o.ben = bus.ball_en_o; o.brst = bus.ball_reset_o;
        o.pen = bus.paddle_en_o; o.p1 = bus.p1_score_o; o.p2 = bus.p2_score_o;
        o.win = bus.winner_o;
        return o;
    endfunction

    task automatic push(input logic r, input logic s, input logic [5:0] bx, input obs_t e);
        step_t st;
        st.rst_n = r; st.start = s; st.bx = bx; st.exp = e;
        sb.push_back(st);
    endtask

    // A full serve: recentre pulse, four SERVE cycles, then the rally.
    task automatic push_serve(input logic s, input logic [5:0] bx,
                              input logic [3:0] a, input logic [3:0] b);
        push(1, s, bx, mk(ST_SERVE, 0, 1, 1, a, b, WIN_NONE));
        for (int i = 0; i < 3; i++) push(1, s, bx, mk(ST_SERVE, 0, 0, 1, a, b, WIN_NONE));
        push(1, s, bx, mk(ST_RUNNING, 1, 0, 1, a, b, WIN_NONE));
    endtask

    task automatic test_reset();
        step_t st; obs_t got; int n = 0;
        push(0, 0, 0, mk(ST_IDLE, 0, 0, 0, 0, 0, WIN_NONE));
        push(0, 0, 0, mk(ST_IDLE, 0, 0, 0, 0, 0, WIN_NONE));
        push(1, 0, 0, mk(ST_IDLE, 0, 0, 0, 0, 0, WIN_NONE));
        push(1, 0, 0, mk(ST_IDLE, 0, 0, 0, 0, 0, WIN_NONE));
        while (sb.size() != 0) begin
            st = sb.pop_front();
            rst_n = st.rst_n; bus.start_i = st.start; bus.ball_x_i = st.bx;
            @(posedge clk); #1;
            got = sample(); compared++; n++;
            if (got !== st.exp) begin
                mismatched++;
                $display("FAIL reset step %0d: got %p required %p", n, got, st.exp);
            end
        end
    endtask

    task automatic test_start_held();
        step_t st; obs_t got; int n = 0;
        push(1, 1, 20, mk(ST_IDLE, 0, 0, 0, 0, 0, WIN_NONE));
        push_serve(1, 20, 0, 0);
        for (int i = 0; i < 14; i++) push(1, 1, 20, mk(ST_RUNNING, 1, 0, 1, 0, 0, WIN_NONE));
        while (sb.size() != 0) begin
            st = sb.pop_front();
            rst_n = st.rst_n; bus.start_i = st.start; bus.ball_x_i = st.bx;
            @(posedge clk); #1;
            got = sample(); compared++; n++;
            if (got !== st.exp) begin
                mismatched++;
                $display("FAIL start_held step %0d: got %p required %p", n, got, st.exp);
            end
        end
    endtask

    task automatic test_p1_point();
        step_t st; obs_t got; int n = 0;
        push(1, 0, 39, mk(ST_POINT, 0, 0, 0, 1, 0, WIN_NONE));
        push_serve(0, 20, 1, 0);
        push(1, 0, 20, mk(ST_RUNNING, 1, 0, 1, 1, 0, WIN_NONE));
        while (sb.size() != 0) begin
            st = sb.pop_front();
            rst_n = st.rst_n; bus.start_i = st.start; bus.ball_x_i = st.bx;
            @(posedge clk); #1;
            got = sample(); compared++; n++;
            if (got !== st.exp) begin
                mismatched++;
                $display("FAIL p1_point step %0d: got %p required %p", n, got, st.exp);
            end
        end
    endtask

    // ball_x held at 0 throughout: ignored while serving, scores each rally.
    task automatic test_p2_game_over();
        step_t st; obs_t got; int n = 0;
        push(1, 0, 0, mk(ST_POINT, 0, 0, 0, 1, 1, WIN_NONE));
        push_serve(0, 0, 1, 1);
        push(1, 0, 0, mk(ST_POINT, 0, 0, 0, 1, 2, WIN_NONE));
        push_serve(0, 0, 1, 2);
        push(1, 0, 0, mk(ST_POINT, 0, 0, 0, 1, 3, WIN_NONE));
        for (int i = 0; i < 4; i++) push(1, 0, 0, mk(ST_GAME_OVER, 0, 0, 0, 1, 3, WIN_P2));
        while (sb.size() != 0) begin
            st = sb.pop_front();
            rst_n = st.rst_n; bus.start_i = st.start; bus.ball_x_i = st.bx;
            @(posedge clk); #1;
            got = sample(); compared++; n++;
            if (got !== st.exp) begin
                mismatched++;
                $display("FAIL p2_game_over step %0d: got %p required %p", n, got, st.exp);
            end
        end
    endtask

    task automatic test_restart();
        step_t st; obs_t got; int n = 0;
        push(1, 1, 20, mk(ST_GAME_OVER, 0, 0, 0, 1, 3, WIN_P2));
        push_serve(1, 20, 0, 0);
        while (sb.size() != 0) begin
            st = sb.pop_front();
            rst_n = st.rst_n; bus.start_i = st.start; bus.ball_x_i = st.bx;
            @(posedge clk); #1;
            got = sample(); compared++; n++;
            if (got !== st.exp) begin
                mismatched++;
                $display("FAIL restart step %0d: got %p required %p", n, got, st.exp);
            end
        end
    endtask

    task automatic test_reset_mid_rally();
        step_t st; obs_t got; int n = 0;
        push(1, 1, 39, mk(ST_POINT, 0, 0, 0, 1, 0, WIN_NONE));
        push_serve(1, 20, 1, 0);
        push(1, 1, 39, mk(ST_POINT, 0, 0, 0, 2, 0, WIN_NONE));
        push_serve(1, 20, 2, 0);
        push(1, 1, 0, mk(ST_POINT, 0, 0, 0, 2, 1, WIN_NONE));
        push_serve(1, 20, 2, 1);
        push(0, 1, 20, mk(ST_IDLE, 0, 0, 0, 0, 0, WIN_NONE));
        for (int i = 0; i < 3; i++) push(1, 1, 20, mk(ST_IDLE, 0, 0, 0, 0, 0, WIN_NONE));
        push(1, 0, 20, mk(ST_IDLE, 0, 0, 0, 0, 0, WIN_NONE));
        push(1, 1, 20, mk(ST_IDLE, 0, 0, 0, 0, 0, WIN_NONE));
        push_serve(1, 20, 0, 0);
        while (sb.size() != 0) begin
            st = sb.pop_front();
            rst_n = st.rst_n; bus.start_i = st.start; bus.ball_x_i = st.bx;
            @(posedge clk); #1;
            got = sample(); compared++; n++;
            if (got !== st.exp) begin
                mismatched++;
                $display("FAIL reset_mid_rally step %0d: got %p required %p", n, got, st.exp);
            end
        end
    endtask

    initial begin
        bus.start_i  = 1'b0;
        bus.ball_x_i = '0;
        test_reset();
        test_start_held();
        test_p1_point();
        test_p2_game_over();
        test_restart();
        test_reset_mid_rally();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
